mul_wb_queue: RTL and testbench



---
 rtl/mul_wb_queue_pkg.sv | 9 +
 rtl/mul_wb_queue_sync_fifo.sv | 56 +++++
 rtl/mul_wb_queue.sv | 60 ++++++
 tb/tb_mul_wb_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mul_wb_queue_pkg.sv
// Default widths shared by the multiply writeback path.
package mul_wb_queue_pkg;

  localparam int unsigned MWQ_WORD_SIZE       = 32;
  localparam int unsigned MWQ_INSTR_TYPE_SZ   = 4;
  localparam int unsigned MWQ_ROB_ENTRY_WIDTH = 6;
  localparam int unsigned MWQ_DEPTH           = 4;

endpackage

// File: rtl/mul_wb_queue_sync_fifo.sv
// Generic in-order FIFO with synchronous reset that also clears storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      mem_d[tail_q] = din;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/mul_wb_queue.sv
// Multiply writeback queue: buffers results until the shared write port grants.
module mul_wb_queue
  import mul_wb_queue_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = MWQ_WORD_SIZE,
  parameter int unsigned INSTR_TYPE_SZ   = MWQ_INSTR_TYPE_SZ,
  parameter int unsigned ROB_ENTRY_WIDTH = MWQ_ROB_ENTRY_WIDTH,
  parameter int unsigned DEPTH           = MWQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic [WORD_SIZE-1:0]       in_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       stall_out,
  input  logic                       wb_grant,
  output logic                       wb_valid,
  output logic [INSTR_TYPE_SZ-1:0]   wb_instruction_type,
  output logic [WORD_SIZE-1:0]       wb_pc,
  output logic [WORD_SIZE-1:0]       wb_result,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] fifo_din;
  logic [PW-1:0] fifo_dout;

  assign full      = (count == FULL_CNT);
  assign wb_valid  = (count != '0);
  assign pop       = wb_valid && wb_grant;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push      = in_valid && (!full || pop);
  assign stall_out = full && !pop;

  assign fifo_din = {in_instruction_type, in_pc, in_result, in_rob_id};
  assign {wb_instruction_type, wb_pc, wb_result, wb_rob_id} = fifo_dout;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count)
  );

endmodule

// File: tb/tb_mul_wb_queue.sv
// Directed bench for mul_wb_queue with default widths and DEPTH=4.
module tb_mul_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_instruction_type;
  logic [31:0] in_pc;
  logic [31:0] in_result;
  logic [5:0]  in_rob_id;
  logic        stall_out;
  logic        wb_grant;
  logic        wb_valid;
  logic [3:0]  wb_instruction_type;
  logic [31:0] wb_pc;
  logic [31:0] wb_result;
  logic [5:0]  wb_rob_id;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_wb_queue dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_instruction_type (in_instruction_type),
    .in_pc               (in_pc),
    .in_result           (in_result),
    .in_rob_id           (in_rob_id),
    .stall_out           (stall_out),
    .wb_grant            (wb_grant),
    .wb_valid            (wb_valid),
    .wb_instruction_type (wb_instruction_type),
    .wb_pc               (wb_pc),
    .wb_result           (wb_result),
    .wb_rob_id           (wb_rob_id),
    .count               (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] rob, input logic [31:0] res,
                       input logic [31:0] pc, input logic [3:0] ty);
    in_valid            = v;
    in_rob_id           = rob;
    in_result           = res;
    in_pc               = pc;
    in_instruction_type = ty;
  endtask

  int q[$];
  int sent;
  int popped;
  int cyc;
  logic g;
  logic exp_stall;

  initial begin
    reset = 1'b1;
    wb_grant = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_valid", wb_valid, 0);
    check("rst_count", count, 0);
    check("rst_stall", stall_out, 0);
    check("rst_type", wb_instruction_type, 0);
    check("rst_pc", wb_pc, 0);
    check("rst_result", wb_result, 0);
    check("rst_rob", wb_rob_id, 0);

    // Single entry
    drive(1'b1, 6'd3, 32'h0000_0042, 32'h100, 4'd2);
    step();
    drive(1'b0, 6'd9, 32'hdead_beef, 32'h999, 4'd7);
    check("single_valid", wb_valid, 1);
    check("single_rob", wb_rob_id, 3);
    check("single_result", wb_result, 32'h42);
    check("single_pc", wb_pc, 32'h100);
    check("single_type", wb_instruction_type, 2);
    check("single_count", count, 1);
    wb_grant = 1'b1;
    step();
    wb_grant = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_valid", wb_valid, 0);
    check("invalid_no_push", count, 0);

    // Fill and stall
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(i), 32'(i * 17), 32'(32'h200 + i * 4), 4'd1);
      step();
    end
    drive(1'b1, 6'd4, 32'd68, 32'h210, 4'd1);
    check("full_count", count, 4);
    check("full_stall", stall_out, 1);
    check("full_head", wb_rob_id, 0);
    step();
    check("held_count", count, 4);
    check("held_head", wb_rob_id, 0);
    wb_grant = 1'b1;
    #1;
    check("grant_unstall", stall_out, 0);
    step();
    wb_grant = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    check("swap_count", count, 4);
    check("swap_head", wb_rob_id, 1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_rob", wb_rob_id, i);
      check("drain_result", wb_result, i * 17);
      wb_grant = 1'b1;
      step();
    end
    wb_grant = 1'b0;
    check("drain_count", count, 0);

    // Order and wrap with alternating grant; queue model as scoreboard
    sent = 0;
    popped = 0;
    g = 1'b1;
    for (cyc = 0; cyc < 100 && (sent < 10 || q.size() > 0); cyc++) begin
      drive(sent < 10, 6'(sent), 32'(32'h1000 + sent), 32'(32'h400 + 4 * sent), 4'd3);
      wb_grant = g;
      #1;
      check("wrap_count", count, q.size());
      exp_stall = (q.size() == 4) && !(g && q.size() > 0);
      check("wrap_stall", stall_out, exp_stall);
      if (g && q.size() > 0) begin
        check("wrap_rob", wb_rob_id, q[0]);
        check("wrap_result", wb_result, 32'h1000 + q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (sent < 10 && !exp_stall) begin
        q.push_back(sent);
        sent++;
      end
      step();
      g = ~g;
    end
    check("wrap_popped", popped, 10);
    wb_grant = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    #1;
    check("wrap_empty", count, 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(16 + i), 32'(i), 32'h500, 4'd5);
      step();
    end
    check("pre_rst_count", count, 3);
    drive(1'b1, 6'd19, 32'h77, 32'h600, 4'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    check("midrst_count", count, 0);
    check("midrst_valid", wb_valid, 0);
    check("midrst_rob", wb_rob_id, 0);
    check("midrst_result", wb_result, 0);
    step();
    check("midrst_nopush", count, 0);

    // Spurious grant on empty queue
    wb_grant = 1'b1;
    step();
    step();
    check("spur_count", count, 0);
    check("spur_valid", wb_valid, 0);
    check("spur_stall", stall_out, 0);
    wb_grant = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
